// File: rtl/tank_move_sched_if.sv
// Bundle between tank_move_sched, the two player input decoders and the storage block.
// The scheduler side uses the master modport; player/storage models use the slave modport.
interface tank_move_sched_if;
    logic       p1_req;
    logic [7:0] p1_dir;
    logic       p1_ack;
    logic       p1_moved;
    logic       p2_req;
    logic [7:0] p2_dir;
    logic       p2_ack;
    logic       p2_moved;
    logic [3:0] st_mode;
    logic       st_wren;
    logic       st_load_out;
    logic [7:0] st_address;
    logic [7:0] st_data;
    logic [7:0] st_q;
    logic       busy;

    modport master (
        input  p1_req, p1_dir, p2_req, p2_dir, st_q,
        output p1_ack, p1_moved, p2_ack, p2_moved,
        output st_mode, st_wren, st_load_out, st_address, st_data, busy
    );

    modport slave (
        output p1_req, p1_dir, p2_req, p2_dir, st_q,
        input  p1_ack, p1_moved, p2_ack, p2_moved,
        input  st_mode, st_wren, st_load_out, st_address, st_data, busy
    );
endinterface

// File: rtl/tank_move_sched.sv
// Round-robin scheduler turning tank move requests into storage access sequences.
// Optional macro TANK_COLLIDE_EN adds a check against the other tank's position.
module tank_move_sched #(
    parameter int         RD_LAT    = 1,
    parameter logic [7:0] WALL_FREE = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    tank_move_sched_if.master bus
);

    typedef enum logic [3:0] {
        IDLE, WR_DIR, RD_POS, WAIT_POS, RD_WALL, WAIT_WALL,
        RD_OTHER, WAIT_OTHER, WR_POS, ACK
    } state_t;

    state_t     state;
    logic       ptr_p2;
    logic       sel_p2;
    logic [7:0] dir_q;
    logic [7:0] target_q;
    logic [2:0] wait_cnt;

    logic       p1_ack, p1_moved, p2_ack, p2_moved;
    logic [3:0] st_mode;
    logic       st_wren, st_load_out;
    logic [7:0] st_address, st_data;
    logic       busy;

    logic       grant_p2;
    logic [7:0] grant_dir;
    logic [8:0] step_res;

    function automatic logic dir_valid(input logic [7:0] dir);
        return (dir == 8'h00) || (dir == 8'h01) || (dir == 8'h03) || (dir == 8'h07);
    endfunction

    function automatic logic [3:0] pos_mode(input logic p2);
        return p2 ? 4'b0100 : 4'b0001;
    endfunction

    function automatic logic [3:0] dir_mode(input logic p2);
        return p2 ? 4'b0101 : 4'b0010;
    endfunction

    // {blocked, target}: up/down move the column nibble, left/right the row nibble
    function automatic logic [8:0] step(input logic [7:0] pos, input logic [7:0] dir);
        case (dir)
            8'h00:   return {pos[7:4] == 4'h0, pos - 8'h10};
            8'h01:   return {pos[7:4] == 4'hF, pos + 8'h10};
            8'h03:   return {pos[3:0] == 4'h0, pos - 8'h01};
            8'h07:   return {pos[3:0] == 4'hF, pos + 8'h01};
            default: return {1'b1, pos};
        endcase
    endfunction

    assign grant_p2  = bus.p2_req && (!bus.p1_req || ptr_p2);
    assign grant_dir = grant_p2 ? bus.p2_dir : bus.p1_dir;
    assign step_res  = step(bus.st_q, dir_q);

    task automatic finish_req(input logic moved);
        state    <= ACK;
        p1_ack   <= !sel_p2;
        p2_ack   <= sel_p2;
        p1_moved <= !sel_p2 && moved;
        p2_moved <= sel_p2 && moved;
    endtask

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr_p2      <= 1'b0;
            sel_p2      <= 1'b0;
            dir_q       <= 8'h00;
            target_q    <= 8'h00;
            wait_cnt    <= 3'd0;
            p1_ack      <= 1'b0;
            p1_moved    <= 1'b0;
            p2_ack      <= 1'b0;
            p2_moved    <= 1'b0;
            st_mode     <= 4'b0000;
            st_wren     <= 1'b0;
            st_load_out <= 1'b0;
            st_address  <= 8'h00;
            st_data     <= 8'h00;
            busy        <= 1'b0;
        end else begin
            st_wren     <= 1'b0;
            st_load_out <= 1'b0;
            p1_ack      <= 1'b0;
            p1_moved    <= 1'b0;
            p2_ack      <= 1'b0;
            p2_moved    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.p1_req || bus.p2_req) begin
                        sel_p2 <= grant_p2;
                        ptr_p2 <= !grant_p2;
                        dir_q  <= grant_dir;
                        busy   <= 1'b1;
                        if (dir_valid(grant_dir)) begin
                            state   <= WR_DIR;
                            st_mode <= dir_mode(grant_p2);
                            st_wren <= 1'b1;
                            st_data <= grant_dir;
                        end else begin
                            // invalid code: acknowledge without touching storage
                            state    <= ACK;
                            p1_ack   <= !grant_p2;
                            p2_ack   <= grant_p2;
                        end
                    end
                end
                WR_DIR: begin
                    state       <= RD_POS;
                    st_mode     <= pos_mode(sel_p2);
                    st_load_out <= 1'b1;
                end
                RD_POS: begin
                    state    <= WAIT_POS;
                    wait_cnt <= 3'(RD_LAT - 1);
                end
                WAIT_POS: begin
                    if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else begin
                        target_q <= step_res[7:0];
                        if (step_res[8]) begin
                            finish_req(1'b0);
                        end else begin
                            state       <= RD_WALL;
                            st_mode     <= 4'b0000;
                            st_address  <= step_res[7:0];
                            st_load_out <= 1'b1;
                        end
                    end
                end
                RD_WALL: begin
                    state    <= WAIT_WALL;
                    wait_cnt <= 3'(RD_LAT - 1);
                end
                WAIT_WALL: begin
                    if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else if (bus.st_q != WALL_FREE) begin
                        finish_req(1'b0);
                    end else begin
`ifdef TANK_COLLIDE_EN
                        state       <= RD_OTHER;
                        st_mode     <= pos_mode(!sel_p2);
                        st_load_out <= 1'b1;
`else
                        state       <= WR_POS;
                        st_mode     <= pos_mode(sel_p2);
                        st_data     <= target_q;
                        st_wren     <= 1'b1;
`endif
                    end
                end
`ifdef TANK_COLLIDE_EN
                RD_OTHER: begin
                    state    <= WAIT_OTHER;
                    wait_cnt <= 3'(RD_LAT - 1);
                end
                WAIT_OTHER: begin
                    if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else if (bus.st_q == target_q) begin
                        finish_req(1'b0);
                    end else begin
                        state   <= WR_POS;
                        st_mode <= pos_mode(sel_p2);
                        st_data <= target_q;
                        st_wren <= 1'b1;
                    end
                end
`endif
                WR_POS: begin
                    finish_req(1'b1);
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.p1_ack      = p1_ack;
    assign bus.p1_moved    = p1_moved;
    assign bus.p2_ack      = p2_ack;
    assign bus.p2_moved    = p2_moved;
    assign bus.st_mode     = st_mode;
    assign bus.st_wren     = st_wren;
    assign bus.st_load_out = st_load_out;
    assign bus.st_address  = st_address;
    assign bus.st_data     = st_data;
    assign bus.busy        = busy;

endmodule

// File: doc/tank_move_sched.md
Name: tank_move_sched

Overview:
- Scheduler that lets the two tank input handlers share the single storage port.
- Each move request is granted round-robin and turned into a fixed sequence of storage accesses: write direction, read position, read wall cell, conditionally write new position.
- Sits between the player input decoders and the storage block; it is the only master driving the storage control inputs.

Parameters:
- RD_LAT, 1, cycles from a st_load_out strobe to valid st_q (1..4).
- WALL_FREE, 8'h00, RAM wall code meaning passable; any other value blocks.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- p1_req  in  1  player 1 move request, held until p1_ack
- p1_dir  in  8  player 1 direction code (00 up, 01 down, 03 left, 07 right)
- p1_ack  out  1  one-cycle completion pulse for player 1
- p1_moved  out  1  valid with p1_ack: 1 = position updated
- p2_req, p2_dir, p2_ack, p2_moved  as player 1, for player 2
- st_mode  out  4  storage mode select (0000 RAM, 0001/0010 tank1 pos/dir, 0100/0101 tank2 pos/dir)
- st_wren  out  1  storage write strobe
- st_load_out  out  1  storage read strobe
- st_address  out  8  RAM cell address for wall reads
- st_data  out  8  write data
- st_q  in  8  storage read data
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset:
  - All outputs 0.
  - FSM enters IDLE.
  - Round-robin pointer favours player 1.
  - Reset mid-sequence aborts the sequence with no ack; the aborted request stays pending and is re-granted later.
- Position format: [7:4] column nibble used for up/down, [3:0] row nibble used for left/right. Same arithmetic as the storage ALU.
- Arbitration in IDLE:
  - Only one requester high: grant it.
  - Both high: grant the player not served last, then flip the pointer.
  - pN_dir is sampled at grant. Later changes to pN_dir are ignored until ack.
- FSM, one storage strobe per cycle:
  - IDLE -> WR_DIR: mode = dir register, wren = 1, data = dir.
  - -> RD_POS: mode = pos register, load_out = 1.
  - -> WAIT_POS: RD_LAT cycles, then capture pos.
  - Compute target from pos and dir:
    - up: pos − 8'h10, blocked if pos[7:4] == 0.
    - down: pos + 8'h10, blocked if pos[7:4] == F.
    - left: pos − 1, blocked if pos[3:0] == 0.
    - right: pos + 1, blocked if pos[3:0] == F.
  - Edge-blocked -> ACK with moved = 0.
  - Otherwise -> RD_WALL: mode 0000, address = target, load_out = 1.
  - -> WAIT_WALL: RD_LAT cycles, capture wall code.
  - Wall != WALL_FREE -> ACK with moved = 0.
  - Wall clear -> WR_POS: mode = pos register, wren = 1, data = target, then -> ACK with moved = 1.
  - ACK: pulse pN_ack and pN_moved for one cycle, -> IDLE.
- Invalid direction code: at grant, go straight to ACK with moved = 0. No storage access, including no direction write.
- Latency: cycle 0 is the IDLE cycle in which req is sampled. Ack appears in:
  - moved: cycle 5 + 2·RD_LAT
  - wall-blocked: cycle 4 + 2·RD_LAT
  - edge-blocked: cycle 3 + RD_LAT
  - invalid direction: cycle 1
- IDLE is held for at least one cycle after ACK, so a requester can drop req.
- st_wren and st_load_out are never both high in the same cycle.
- st_mode holds its last value when neither strobe is asserted.

Optional Feature:
- TANK_COLLIDE_EN defined:
  - After a clear wall check, insert RD_OTHER: read the other tank's position register (load_out = 1), then wait RD_LAT cycles.
  - If target equals the other tank's position, ACK with moved = 0.
  - The moved path takes an extra 1 + RD_LAT cycles.
- Undefined: no other-tank check; tanks may overlap.

Test Plan:
- Reset, then p1 down (01) with tank1 at 8'h22 and RAM[8'h32] = 00 -> write dir2=... no: write tank1_dir = 01, read 22, read RAM 32, write tank1 = 8'h32. p1_ack with moved = 1 in cycle 7 (RD_LAT = 1).
- p2 up (00) with tank2 at 8'h0B -> edge-blocked. No RD_WALL and no write of pos. p2_ack with moved = 0 in cycle 4.
- p1 right (07) with tank1 at 8'h45 and RAM[8'h46] = 01 -> tank1 unchanged, p1_ack with moved = 0 in cycle 6.
- p1_req and p2_req both high for 3 back-to-back requests each -> grant order p1, p2, p1, p2, p1, p2. Never two acks in the same cycle.
- p2_dir = 8'h05 -> p2_ack with moved = 0 in cycle 1. st_wren and st_load_out stay 0 throughout.
- Reset asserted during WAIT_WALL -> all outputs 0 next cycle and no ack. The request, still high, is re-executed in full after reset releases.
